// File: rtl/diferential_cfg_loader.sv
// Serial 2-bit config loader: sync 8'h9C, 48 payload symbols, 4 checksum symbols; commits 1 cycle after the last one.
// cfg_en=0 stalls all state indefinitely, so the source can pause without a timeout.
module diferential_cfg_loader #(
  parameter int CELLS         = 12,
  parameter int CELL_CFG_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_en,
  input  logic [1:0]                     cfg_din,
  output logic [CELLS*CELL_CFG_BITS-1:0] cfg_out,
  output logic                           cfg_valid,
  output logic                           cfg_done,
  output logic                           cfg_busy,
  output logic                           cfg_err
);

  localparam int          W        = CELLS * CELL_CFG_BITS;
  localparam int          NSYM     = W / 2;
  localparam logic [5:0]  LAST_PAY = 6'(NSYM - 1);
  localparam logic [7:0]  SYNC     = 8'h9C;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t         state_q, state_d;
  logic [7:0]     sync_q, sync_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [7:0]     csum_q, csum_d;
  logic [7:0]     rxck_q, rxck_d;
  logic [W-1:0]   out_q, out_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;

  logic [7:0]     win, rx_byte, rx_ck;

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    rxck_d   = rxck_q;
    out_d    = out_q;
    valid_d  = valid_q;
    err_d    = err_q;
    done_d   = 1'b0;
    win      = {sync_q[5:0], cfg_din};
    // the three earlier symbols of the current byte are still in the shadow LSBs
    rx_byte  = {shadow_q[5:0], cfg_din};
    rx_ck    = {rxck_q[5:0], cfg_din};

    if (cfg_en) begin
      case (state_q)
        IDLE: begin
          if (win == SYNC) begin
            state_d = LOAD;
            sync_d  = 8'h00;
            err_d   = 1'b0;
            csum_d  = 8'h00;
            cnt_d   = 6'd0;
          end else begin
            sync_d = win;
          end
        end
        LOAD: begin
          shadow_d = {shadow_q[W-3:0], cfg_din};
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q[1:0] == 2'd3) csum_d = csum_q ^ rx_byte;
          if (cnt_q == LAST_PAY) begin
            state_d = CHECK;
            cnt_d   = 6'd0;
          end
        end
        CHECK: begin
          rxck_d = rx_ck;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd3) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            sync_d  = 8'h00;
            if (rx_ck == csum_q) begin
              out_d   = shadow_q;
              valid_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sync_q   <= 8'h00;
      shadow_q <= '0;
      cnt_q    <= 6'd0;
      csum_q   <= 8'h00;
      rxck_q   <= 8'h00;
      out_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      rxck_q   <= rxck_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign cfg_out   = out_q;
  assign cfg_valid = valid_q;
  assign cfg_done  = done_q;
  assign cfg_busy  = busy_q;
  assign cfg_err   = err_q;

endmodule
